// File: rtl/bridge_n.sv
// CPU data-port bridge: decodes up to six 16-byte device windows and runs each access
// as a registered request/acknowledge transaction with a timeout, plus interrupt registering.
module bridge_n #(
   parameter int          NDEV    = 2,
   parameter logic [27:0] BASE    = 28'h0000_7f0,
   parameter int          TIMEOUT = 16,
   parameter logic [31:0] MISS_RD = 32'haabb_ccdd
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 PrReq,
   input  logic                 PrWe,
   input  logic [31:2]          PrAddr,
   input  logic [3:0]           PrBe,
   input  logic [31:0]          PrWD,
   output logic [31:0]          PrRD,
   output logic                 PrReady,
   output logic                 PrErr,
   output logic [NDEV-1:0]      DevSel,
   output logic                 DevWe,
   output logic [3:2]           DevAddr,
   output logic [31:0]          DevWd,
   input  logic [NDEV*32-1:0]   DevRD,
   input  logic [NDEV-1:0]      DevAck,
   input  logic [NDEV-1:0]      DevIrq,
   output logic [7:2]           HWInt
);

   localparam int CW = $clog2(TIMEOUT);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NDEV-1:0] sel_q, sel_d;
   logic            we_q, we_d;
   logic [1:0]      addr_q, addr_d;
   logic [31:0]     wd_q, wd_d;
   logic [31:0]     rd_q, rd_d;
   logic            err_q, err_d;
   logic [5:0]      hwint_q, hwint_d;

   logic [NDEV-1:0] hit;
   logic [31:0]     rd_and [NDEV];
   logic [31:0]     rd_mux;
   logic            ack_sel;
   logic            partial_wr;

   // Per-device window decode and AND-OR read-data mux driven by the registered select.
   for (genvar gi = 0; gi < NDEV; gi++) begin : g_dev
      assign hit[gi]    = (PrAddr[31:4] == BASE + 28'(gi));
      assign rd_and[gi] = DevRD[gi*32 +: 32] & {32{sel_q[gi]}};
   end

   always_comb begin
      rd_mux = '0;
      for (int k = 0; k < NDEV; k++) begin
         rd_mux = rd_mux | rd_and[k];
      end
   end

   for (genvar gi = 0; gi < 6; gi++) begin : g_irq
      if (gi < NDEV) begin : g_used
         assign hwint_d[gi] = DevIrq[gi];
      end else begin : g_unused
         assign hwint_d[gi] = 1'b0;
      end
   end

   assign ack_sel    = |(DevAck & sel_q);
   assign partial_wr = PrWe && (PrBe != 4'b1111);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wd_d    = wd_q;
      rd_d    = rd_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (PrReq) begin
               addr_d = PrAddr[3:2];
               wd_d   = PrWD;
               cnt_d  = '0;
               if ((|hit) && !partial_wr) begin
                  state_d = S_WAIT;
                  sel_d   = hit;
                  we_d    = PrWe;
               end else begin
                  state_d = S_DONE;
                  sel_d   = '0;
                  we_d    = 1'b0;
                  err_d   = 1'b1;
                  rd_d    = MISS_RD;
               end
            end
         end
         S_WAIT: begin
            // An ack in the final counted cycle still beats the timeout.
            if (ack_sel) begin
               state_d = S_DONE;
               sel_d   = '0;
               we_d    = 1'b0;
               err_d   = 1'b0;
               rd_d    = we_q ? 32'h0 : rd_mux;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = S_DONE;
               sel_d   = '0;
               we_d    = 1'b0;
               err_d   = 1'b1;
               rd_d    = MISS_RD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            sel_d   = '0;
            we_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wd_q    <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
         hwint_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         hwint_q <= hwint_d;
      end
   end

   assign PrRD    = rd_q;
   assign PrErr   = err_q;
   assign PrReady = (state_q == S_DONE);
   assign DevSel  = sel_q;
   assign DevWe   = we_q;
   assign DevAddr = addr_q;
   assign DevWd   = wd_q;
   assign HWInt   = hwint_q;

endmodule

// File: tb/tb_bridge_n.sv
// Directed self-checking bench for bridge_n: decode, ack/timeout paths, reset abort, interrupts.
module tb_bridge_n;

   localparam int NDEV = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              PrReq, PrWe;
   logic [31:2]       PrAddr;
   logic [3:0]        PrBe;
   logic [31:0]       PrWD, PrRD;
   logic              PrReady, PrErr;
   logic [NDEV-1:0]   DevSel;
   logic              DevWe;
   logic [3:2]        DevAddr;
   logic [31:0]       DevWd;
   logic [NDEV*32-1:0] DevRD;
   logic [NDEV-1:0]   DevAck, DevIrq;
   logic [7:2]        HWInt;

   logic [5:0]        irq6;
   logic [7:2]        hwint6;
   logic [31:0]       rd6, wd6;
   logic              rdy6, err6, we6;
   logic [5:0]        sel6;
   logic [3:2]        addr6;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   bridge_n #(.NDEV(NDEV)) u_dut (
      .clk(clk), .rst(rst), .PrReq(PrReq), .PrWe(PrWe), .PrAddr(PrAddr), .PrBe(PrBe),
      .PrWD(PrWD), .PrRD(PrRD), .PrReady(PrReady), .PrErr(PrErr), .DevSel(DevSel),
      .DevWe(DevWe), .DevAddr(DevAddr), .DevWd(DevWd), .DevRD(DevRD), .DevAck(DevAck),
      .DevIrq(DevIrq), .HWInt(HWInt)
   );

   bridge_n #(.NDEV(6)) u_dut6 (
      .clk(clk), .rst(rst), .PrReq(1'b0), .PrWe(1'b0), .PrAddr(30'h0), .PrBe(4'h0),
      .PrWD(32'h0), .PrRD(rd6), .PrReady(rdy6), .PrErr(err6), .DevSel(sel6),
      .DevWe(we6), .DevAddr(addr6), .DevWd(wd6), .DevRD(192'h0), .DevAck(6'h0),
      .DevIrq(irq6), .HWInt(hwint6)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one access and holds it until PrReady; acks with ack_mask during the
   // ack_at-th cycle in which DevSel is seen (0 = never). Returns at the PrReady negedge.
   task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, input int ack_at, input logic [1:0] ack_mask,
                             output int lat, output int sel_cyc, output int we_cyc,
                             output logic [1:0] sel_seen, output logic [31:0] wd_seen,
                             output logic done);
      lat = 0; sel_cyc = 0; we_cyc = 0; sel_seen = '0; wd_seen = '0; done = 1'b0;
      @(negedge clk);
      PrReq = 1'b1; PrWe = we; PrAddr = addr[31:2]; PrBe = be; PrWD = wd;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         DevAck = '0;
         if (PrReady) begin
            done  = 1'b1;
            PrReq = 1'b0;
            break;
         end
         if (DevSel != '0) begin
            sel_cyc++;
            sel_seen = sel_seen | DevSel;
            wd_seen  = DevWd;
            if (DevWe) we_cyc++;
            if (sel_cyc == ack_at) DevAck = ack_mask;
         end
      end
      PrReq = 1'b0;
   endtask

   int         lat, sel_cyc, we_cyc;
   logic [1:0] sel_seen;
   logic [31:0] wd_seen;
   logic       done;
   logic [1:0] addr_seen;

   initial begin
      rst = 1'b1; PrReq = 1'b0; PrWe = 1'b0; PrAddr = '0; PrBe = '0; PrWD = '0;
      DevRD = '0; DevAck = '0; DevIrq = '0; irq6 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_prrd", PrRD, 32'h0);
      chk("rst_ready", 32'(PrReady), 32'h0);
      chk("rst_err", 32'(PrErr), 32'h0);
      chk("rst_sel", 32'(DevSel), 32'h0);
      chk("rst_hwint", 32'(HWInt), 32'h0);
      rst = 1'b0;

      // Read dev1, ack in first WAIT cycle.
      DevRD = {32'h1234_5678, 32'hCAFE_0000};
      @(negedge clk);
      PrReq = 1'b1; PrWe = 1'b0; PrAddr = 30'(32'h0000_7F14 >> 2); PrBe = 4'h0;
      @(posedge clk);
      @(negedge clk);
      chk("rd1_sel", 32'(DevSel), 32'h2);
      chk("rd1_addr", 32'(DevAddr), 32'h1);
      chk("rd1_we", 32'(DevWe), 32'h0);
      chk("rd1_ready_early", 32'(PrReady), 32'h0);
      DevAck = 2'b10;
      @(posedge clk);
      @(negedge clk);
      DevAck = '0; PrReq = 1'b0;
      chk("rd1_ready", 32'(PrReady), 32'h1);
      chk("rd1_prrd", PrRD, 32'h1234_5678);
      chk("rd1_err", 32'(PrErr), 32'h0);
      chk("rd1_sel_drop", 32'(DevSel), 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("rd1_ready_pulse", 32'(PrReady), 32'h0);
      chk("rd1_prrd_hold", PrRD, 32'h1234_5678);

      // Full write to dev0, ack in the 4th WAIT cycle.
      run_access(1'b1, 32'h0000_7F08, 4'hF, 32'hDEAD_BEEF, 4, 2'b01,
                 lat, sel_cyc, we_cyc, sel_seen, wd_seen, done);
      chk("wr_done", 32'(done), 32'h1);
      chk("wr_sel_cycles", 32'(sel_cyc), 32'd4);
      chk("wr_we_cycles", 32'(we_cyc), 32'd4);
      chk("wr_sel", 32'(sel_seen), 32'h1);
      chk("wr_wd", wd_seen, 32'hDEAD_BEEF);
      chk("wr_lat", 32'(lat), 32'd5);
      chk("wr_err", 32'(PrErr), 32'h0);
      chk("wr_prrd", PrRD, 32'h0);
      addr_seen = DevAddr;
      chk("wr_addr", 32'(addr_seen), 32'h2);

      // Partial write to dev0.
      run_access(1'b1, 32'h0000_7F08, 4'b0011, 32'h1111_2222, 0, 2'b00,
                 lat, sel_cyc, we_cyc, sel_seen, wd_seen, done);
      chk("pw_done", 32'(done), 32'h1);
      chk("pw_lat", 32'(lat), 32'd1);
      chk("pw_sel_cycles", 32'(sel_cyc), 32'd0);
      chk("pw_err", 32'(PrErr), 32'h1);
      chk("pw_prrd", PrRD, 32'haabb_ccdd);
      @(negedge clk);

      // Read to an unmapped window (BASE+3 with two devices).
      run_access(1'b0, 32'h0000_7F30, 4'h0, 32'h0, 0, 2'b00,
                 lat, sel_cyc, we_cyc, sel_seen, wd_seen, done);
      chk("miss_done", 32'(done), 32'h1);
      chk("miss_lat", 32'(lat), 32'd1);
      chk("miss_sel_cycles", 32'(sel_cyc), 32'd0);
      chk("miss_err", 32'(PrErr), 32'h1);
      chk("miss_prrd", PrRD, 32'haabb_ccdd);

      // Clear PrErr/PrRD with a good read of dev0 so the timeout result is visible.
      run_access(1'b0, 32'h0000_7F00, 4'h0, 32'h0, 1, 2'b01,
                 lat, sel_cyc, we_cyc, sel_seen, wd_seen, done);
      chk("rd0_prrd", PrRD, 32'hCAFE_0000);
      chk("rd0_lat", 32'(lat), 32'd2);

      // Read dev1 with only a non-selected ack: must time out.
      run_access(1'b0, 32'h0000_7F1C, 4'h0, 32'h0, 1, 2'b01,
                 lat, sel_cyc, we_cyc, sel_seen, wd_seen, done);
      chk("to_done", 32'(done), 32'h1);
      chk("to_lat", 32'(lat), 32'd17);
      chk("to_sel_cycles", 32'(sel_cyc), 32'd16);
      chk("to_err", 32'(PrErr), 32'h1);
      chk("to_prrd", PrRD, 32'haabb_ccdd);
      DevAck = 2'b10;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("late_ack_ready", 32'(PrReady), 32'h0);
      end
      DevAck = '0;
      chk("late_ack_prrd", PrRD, 32'haabb_ccdd);
      chk("late_ack_sel", 32'(DevSel), 32'h0);

      // Reset during WAIT abandons the access.
      @(negedge clk);
      PrReq = 1'b1; PrWe = 1'b1; PrBe = 4'hF; PrWD = 32'h5555_AAAA;
      PrAddr = 30'(32'h0000_7F1C >> 2);
      DevIrq = 2'b01;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rw_sel", 32'(DevSel), 32'h2);
      chk("rw_we", 32'(DevWe), 32'h1);
      rst = 1'b1; PrReq = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; DevIrq = '0;
      chk("rw_sel0", 32'(DevSel), 32'h0);
      chk("rw_we0", 32'(DevWe), 32'h0);
      chk("rw_prrd0", PrRD, 32'h0);
      chk("rw_err0", 32'(PrErr), 32'h0);
      chk("rw_addr0", 32'(DevAddr), 32'h0);
      chk("rw_wd0", DevWd, 32'h0);
      chk("rw_hwint0", 32'(HWInt), 32'h0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rw_no_ready", 32'(PrReady), 32'h0);
      end
      run_access(1'b0, 32'h0000_7F14, 4'h0, 32'h0, 2, 2'b10,
                 lat, sel_cyc, we_cyc, sel_seen, wd_seen, done);
      chk("post_rst_done", 32'(done), 32'h1);
      chk("post_rst_lat", 32'(lat), 32'd3);
      chk("post_rst_prrd", PrRD, 32'h1234_5678);
      chk("post_rst_err", 32'(PrErr), 32'h0);

      // Interrupt registering.
      @(negedge clk);
      DevIrq = 2'b11; irq6 = 6'b101001;
      #1;
      chk("irq2_before", 32'(HWInt), 32'h0);
      chk("irq6_before", 32'(hwint6), 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("irq2_after", 32'(HWInt), 32'h03);
      chk("irq6_after", 32'(hwint6), 32'h29);
      DevIrq = 2'b10; irq6 = 6'b010110;
      @(posedge clk);
      @(negedge clk);
      chk("irq2_next", 32'(HWInt), 32'h02);
      chk("irq6_next", 32'(hwint6), 32'h16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bridge_n.md
# bridge_n

Parametrised system bridge between the CPU data port and up to six memory-mapped peripherals. It decodes the word address into one 16-byte window per device and runs each access as a registered request/acknowledge transaction. Missing or hung devices complete with a bus error through a per-access timeout instead of stalling the pipeline. It also registers device interrupt lines onto the CPU's HWInt[7:2] inputs. It replaces the fixed two-device combinational bridge and sits between the MEM stage and the timer/IO devices.

## Interface
- NDEV, 2: number of devices, legal range 1..6.
- BASE, 28'h0000_7f0: PrAddr[31:4] value of device 0. Device k answers at BASE+k.
- TIMEOUT, 16: maximum WAIT cycles before a bus error, legal range 2..256.
- MISS_RD, 32'haabb_ccdd: PrRD value returned on a miss, partial write or timeout.

- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous reset, active-high.
- PrReq, in, 1: access request. Level signal, held with all Pr* inputs until PrReady is seen.
- PrWe, in, 1: 1 = write, 0 = read.
- PrAddr, in, [31:2]: word address.
- PrBe, in, 4: byte enables.
- PrWD, in, 32: write data.
- PrRD, out, 32: read data, registered, valid while PrReady=1.
- PrReady, out, 1: one-cycle completion pulse.
- PrErr, out, 1: bus error, valid while PrReady=1.
- DevSel, out, NDEV: one-hot device select, registered.
- DevWe, out, 1: write strobe to the selected device.
- DevAddr, out, [3:2]: register index within the window.
- DevWd, out, 32: write data to the device.
- DevRD, in, NDEV*32: read data. Device k drives bits [32k+31:32k].
- DevAck, in, NDEV: per-device acknowledge.
- DevIrq, in, NDEV: device interrupt lines.
- HWInt, out, [7:2]: registered interrupts to the CP0 cause register.

## Operation
- FSM has three states: IDLE, WAIT, DONE. Reset state is IDLE.
- In IDLE with PrReq=1, the bridge latches PrWe, PrAddr[3:2] into DevAddr, PrWD into DevWd, and the decode result. Transitions from IDLE:
  - Hit on device k (PrAddr[31:4]==BASE+k, k<NDEV), read or PrBe==4'b1111 write: go to WAIT. DevSel[k]=1, DevWe=PrWe, timeout counter cleared to 0.
  - Hit with a write and PrBe!=4'b1111: go to DONE. PrErr=1, PrRD=MISS_RD, no DevSel.
  - Miss: go to DONE. PrErr=1, PrRD=MISS_RD.
- In WAIT, only DevAck of the selected device counts; acks from other devices are ignored.
  - Ack on a read: PrRD captures the DevRD slice; go to DONE with PrErr=0.
  - Ack on a write: PrRD=0; go to DONE with PrErr=0.
  - No ack with counter==TIMEOUT-1: go to DONE with PrErr=1, PrRD=MISS_RD. DevSel and DevWe drop on the same edge.
  - Otherwise: counter increments and the state stays WAIT.
  - If ack and timeout occur in the same cycle, the ack wins.
- Leaving WAIT clears DevSel and DevWe.
- DONE: PrReady=1 for exactly one cycle, then go to IDLE. PrRD and PrErr hold their values until the next completion.
- Reads ignore PrBe. Devices see exactly one DevSel assertion per access. DevWe is never high unless DevSel is nonzero.
- Interrupts: HWInt[2+k] <= DevIrq[k] every cycle for k<NDEV. Unused HWInt bits are constant 0. No masking in the bridge.
- Reset mid-transaction abandons the access. No PrReady is issued, and the CPU must reissue the access.

## Timing
- Reset values: PrRD=0, PrReady=0, PrErr=0, DevSel=0, DevWe=0, DevAddr=0, DevWd=0, HWInt=0, counter=0, state IDLE.
- Request sampled at edge E0: DevSel is valid after E0. An ack in that same cycle puts PrReady high after E1. Minimum latency is 2 cycles from the request edge.
- Miss or partial write: PrReady is high after E0, so latency is 1 cycle.
- Timeout: PrReady rises TIMEOUT+1 cycles after E0.
- The CPU drops PrReq in the cycle after PrReady unless it issues a back-to-back access. A PrReq still high in IDLE starts a new transaction.
- HWInt lags DevIrq by exactly 1 cycle.

## Test plan
- NDEV=2, read 0x0000_7F14, dev1 acks in the first WAIT cycle with DevRD=0x1234_5678 -> DevSel=2'b10 for 1 cycle, DevAddr=2'b01, PrReady 2 cycles after the request with PrRD=0x1234_5678 and PrErr=0.
- Write 0x0000_7F08, PrBe=4'b1111, PrWD=0xDEAD_BEEF, dev0 acks after 3 WAIT cycles -> DevSel=2'b01 and DevWe=1 for exactly 4 cycles with DevWd=0xDEAD_BEEF. PrErr=0.
- Write with PrBe=4'b0011 to dev0, and a separate read at 0x0000_7F30 (miss) -> each completes in 1 cycle with PrErr=1 and PrRD=0xaabb_ccdd. DevSel stays 0.
- TIMEOUT=16, read dev1 with no ack -> PrReady exactly 17 cycles after the request, PrErr=1, PrRD=0xaabb_ccdd. A late ack after that is ignored.
- Assert rst during WAIT, then release -> all outputs 0 on the next edge, no PrReady. A following access completes normally.
- NDEV=6, drive DevIrq=6'b101001 -> HWInt=6'b101001 one cycle later. NDEV=2 with DevIrq=2'b11 -> HWInt=6'b000011.
